// File: rtl/sdpram_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sdpram_pipe
//  Description : Simple dual-port RAM with byte-lane write enables, a
//                pipelined read path of 1..3 cycles, selectable
//                read-during-write behaviour and optional clear-after-reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdpram_pipe #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    READ_LATENCY   = 2,
  parameter int                    RDW_NEW_DATA   = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]            addr_in,
  input  logic [DATA_WIDTH-1:0]            d,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            addr_out,
  output logic [DATA_WIDTH-1:0]            q,
  output logic                             q_valid,
  output logic                             busy
);

  localparam int NB        = DATA_WIDTH / BYTE_WIDTH;
  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_STEP  = 1;

  // Parameter legality is enforced at elaboration time.
  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
      $error("sdpram_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_bad_latency
      $error("sdpram_pipe: READ_LATENCY must be in the range 1..3");
    end
  endgenerate

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  run;
  logic                  usr_wr;
  logic                  clr_wr;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  // Read pipeline: stage 0 captures the array output, the last stage is q.
  // Every stage loads only when a valid result arrives, so q holds its
  // last delivered value between results.
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_d [READ_LATENCY];

  assign run     = (state_q == ST_RUN);
  assign busy    = (state_q == ST_CLEAR);
  assign usr_wr  = run && wr_en && !rst;
  assign clr_wr  = !run && !rst;
  assign rd_acc  = run && rd_en && !rst;

  assign q       = dat_q[READ_LATENCY-1];
  assign q_valid = vld_q[READ_LATENCY-1];

  // Clear sequencer: walk the pointer once through the array, then run.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + PTR_STEP;
      if (clr_ptr_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end
    end
  end

  // State and clear-pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Memory array: clear writes take priority (user writes are blocked
  // during clear anyway); rst never touches the contents directly.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_ptr_q] <= CLEAR_VALUE;
    end else if (usr_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[addr_in][i*BYTE_WIDTH +: BYTE_WIDTH] <= d[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Array read with optional same-address bypass of the concurrent write,
  // so new-data mode returns the merged word in the same latency.
  always_comb begin
    rd_word = mem[addr_out];
    if ((RDW_NEW_DATA != 0) && usr_wr && (addr_in == addr_out)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = d[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read pipeline next-state: valid bits shift, data follows valid.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? rd_word : dat_q[0];
    for (int s = 1; s < READ_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      dat_d[s] = vld_q[s-1] ? dat_q[s-1] : dat_q[s];
    end
  end

  // Read pipeline registers; reset drops any in-flight read and zeroes q.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < READ_LATENCY; s++) begin
        dat_q[s] <= dat_d[s];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdpram_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdpram_pipe
//  Description : Self-checking bench for sdpram_pipe with a word-array
//                reference model, a per-cycle compare process and directed
//                literal checks of clear, latency, byte lanes, RDW and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdpram_pipe;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 16;
  localparam int RDW   = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [NB-1:0] wr_be;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] d;
  logic          rd_en;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          busy;

  always #5 clk = ~clk;

  sdpram_pipe #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .BYTE_WIDTH    (8),
    .READ_LATENCY  (LAT),
    .RDW_NEW_DATA  (RDW),
    .CLEAR_ON_RESET(1),
    .CLEAR_VALUE   (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_be   (wr_be),
    .addr_in (addr_in),
    .d       (d),
    .rd_en   (rd_en),
    .addr_out(addr_out),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model state
  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_q;
  logic [DW-1:0] m_word;
  int unsigned   edge_n    = 0;
  int            busy_left = 0;
  bit            started   = 1'b0;
  bit            exp_v;
  rd_t           pend [$];
  logic [DW-1:0] got  [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nd,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[i*8 +: 8] = nd[i*8 +: 8];
    end
    return r;
  endfunction

  // Model: a reset starts a DEPTH-cycle clear that zeroes memory and drops
  // pending reads; afterwards reads are scheduled LAT cycles out.
  initial begin
    m_q = '0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        started   = 1'b1;
        pend.delete();
        m_q       = '0;
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end else if (busy_left > 0) begin
        busy_left--;
      end else begin
        if (rd_en) begin
          m_word = m_mem[addr_out];
          if (RDW != 0 && wr_en && addr_in == addr_out) m_word = merge(m_word, d, wr_be);
          pend.push_back('{edge_n + LAT - 1, m_word});
        end
        if (wr_en) m_mem[addr_in] = merge(m_mem[addr_in], d, wr_be);
      end
    end
  end

  // Compare process: every cycle after the first reset.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        exp_v = (pend.size() > 0) && (pend[0].due == edge_n);
        check("busy", DW'(busy), DW'(busy_left > 0));
        if (exp_v) begin
          check("q_valid", DW'(q_valid), DW'(1'b1));
          check("q_data", q, pend[0].data);
          m_q = pend[0].data;
          got.push_back(q);
          void'(pend.pop_front());
        end else begin
          check("q_valid_idle", DW'(q_valid), DW'(1'b0));
          check("q_hold", q, m_q);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic [NB-1:0] be,
                       input logic [AW-1:0] wa, input logic [AW-1:0] ra, input logic [DW-1:0] dd);
    wr_en    = w;
    rd_en    = r;
    wr_be    = be;
    addr_in  = wa;
    addr_out = ra;
    d        = dd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic drive_rand();
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom),
          AW'($urandom), AW'($urandom), $urandom);
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    #1;
    while (got.size() < n && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (got.size() < n) begin
      checks++;
      fails++;
      $display("FAIL wait_got: got %0d results expected %0d", got.size(), n);
    end
  endtask

  // Counts busy cycles while random requests are offered during clear.
  task automatic clear_window(input string tag);
    int bc;
    int qv;
    bc = 0;
    qv = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy) bc++;
      if (q_valid) qv++;
      drive_rand();
    end
    check({tag, "_busy_cycles"}, DW'(bc), DW'(16));
    check({tag, "_no_qvalid"}, DW'(qv), DW'(0));
    check({tag, "_busy_done"}, DW'(busy), DW'(1'b0));
  endtask

  logic [DW-1:0] wv [DEPTH];

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
    addr_in = '0; addr_out = '0; d = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_q", q, 32'h0);
    check("reset_qvalid", DW'(q_valid), DW'(1'b0));
    check("reset_busy", DW'(busy), DW'(1'b1));
    rst = 1'b0;

    // Clear after reset, with requests toggling
    clear_window("clear");
    got.delete();
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 1'b1, '0, '0, AW'(a), '0);
    idle();
    wait_got(DEPTH);
    for (int a = 0; a < DEPTH && a < got.size(); a++) check("clear_word", got[a], 32'h0);

    // Latency
    drive(1'b1, 1'b0, 4'hF, 4'd3, 4'd0, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 4'h0, 4'd0, 4'd3, 32'h0);
    check("lat_t1_valid", DW'(q_valid), DW'(1'b0));
    idle();
    check("lat_t2_valid", DW'(q_valid), DW'(1'b1));
    check("lat_t2_q", q, 32'hDEADBEEF);
    idle();
    check("lat_t3_valid", DW'(q_valid), DW'(1'b0));
    check("lat_t3_hold", q, 32'hDEADBEEF);

    // Byte enables
    drive(1'b1, 1'b0, 4'hF, 4'd5, 4'd0, 32'h11223344);
    drive(1'b1, 1'b0, 4'b0101, 4'd5, 4'd0, 32'hAABBCCDD);
    drive(1'b0, 1'b1, 4'h0, 4'd0, 4'd5, 32'h0);
    idle();
    check("be_q", q, 32'h11BB33DD);

    // Read during write, same address
    drive(1'b1, 1'b0, 4'hF, 4'd7, 4'd0, 32'h0);
    drive(1'b1, 1'b1, 4'hF, 4'd7, 4'd7, 32'hCAFEF00D);
    idle();
    check("rdw_q", q, (RDW != 0) ? 32'hCAFEF00D : 32'h0);
    drive(1'b0, 1'b1, 4'h0, 4'd0, 4'd7, 32'h0);
    idle();
    check("rdw_after_q", q, 32'hCAFEF00D);

    // Streaming reads of random contents
    for (int a = 0; a < DEPTH; a++) begin
      wv[a] = $urandom;
      drive(1'b1, 1'b0, 4'hF, AW'(a), 4'd0, wv[a]);
    end
    got.delete();
    for (int a = 0; a < DEPTH; a++) drive(1'b0, 1'b1, '0, '0, AW'(a), '0);
    idle();
    wait_got(DEPTH);
    for (int a = 0; a < DEPTH && a < got.size(); a++) check("stream_word", got[a], wv[a]);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive_rand();
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) idle();

    // Reset one cycle after a read is issued
    drive(1'b1, 1'b0, 4'hF, 4'd3, 4'd0, 32'h12345678);
    drive(1'b0, 1'b1, 4'h0, 4'd0, 4'd3, 32'h0);
    rst = 1'b1;
    idle();
    check("rstmid_qvalid", DW'(q_valid), DW'(1'b0));
    check("rstmid_q", q, 32'h0);
    rst = 1'b0;
    clear_window("rstmid");
    drive(1'b0, 1'b1, 4'h0, 4'd0, 4'd3, 32'h0);
    idle();
    check("rstmid_reclear_valid", DW'(q_valid), DW'(1'b1));
    check("rstmid_reclear_q", q, 32'h0);

    for (int i = 0; i < 4; i++) idle();
    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdpram_pipe.md
SDPRAM_PIPE -- requirements
Module: sdpram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; depth RAM_DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, write-enable lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes.
REQ-004 SHALL have parameter READ_LATENCY, default 2, rd_en-to-q cycles, legal range 1..3.
REQ-005 SHALL have parameter RDW_NEW_DATA, default 1: 1 = same-address read-during-write returns new data, 0 = old data.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = memory cleared after reset, 0 = contents retained.
REQ-007 SHALL have parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit word written during clear.
REQ-008 SHALL have a single clock and a synchronous, active-high reset; all other requirements reference the ports below.
REQ-009 clk  input  1  sole clock; all state updates on rising edge.
REQ-010 rst  input  1  synchronous active-high reset.
REQ-011 wr_en  input  1  write request.
REQ-012 wr_be  input  NB  per-lane write enable; lane i = d[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-013 addr_in  input  ADDR_WIDTH  write address.
REQ-014 d  input  DATA_WIDTH  write data.
REQ-015 rd_en  input  1  read request.
REQ-016 addr_out  input  ADDR_WIDTH  read address.
REQ-017 q  output  DATA_WIDTH  read data, registered.
REQ-018 q_valid  output  1  one-cycle pulse marking q as new read result.
REQ-019 busy  output  1  high while clear in progress; requests ignored.

Function
REQ-020 SHALL implement FSM states CLEAR and RUN; rst sampled high -> CLEAR (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0).
REQ-021 Entering CLEAR SHALL set clear pointer to 0; each CLEAR cycle with rst low SHALL write CLEAR_VALUE to mem[pointer], all lanes, then increment.
REQ-022 After writing address RAM_DEPTH-1, FSM SHALL move to RUN next cycle; busy high exactly RAM_DEPTH cycles after rst deasserts.
REQ-023 busy SHALL equal (state == CLEAR), combinationally from state register.
REQ-024 In CLEAR, wr_en and rd_en SHALL be ignored: no user write, no q_valid pulse.
REQ-025 In RUN, wr_en=1 SHALL write lanes with wr_be[i]=1 at addr_in; lanes with wr_be[i]=0 unchanged; wr_be all-zero = no change.
REQ-026 In RUN, rd_en=1 sampled at cycle t SHALL present mem[addr_out] on q and pulse q_valid=1 at cycle t+READ_LATENCY.
REQ-027 Back-to-back reads SHALL be accepted every cycle; throughput one read per cycle, results in issue order.
REQ-028 q SHALL hold its last value when no read result is delivered; q_valid=0 those cycles.
REQ-029 Same-cycle rd_en and wr_en to equal addresses, RDW_NEW_DATA=1: q SHALL return merged word (enabled lanes from d, others from old contents).
REQ-030 Same case, RDW_NEW_DATA=0: q SHALL return pre-write contents.
REQ-031 Differing addresses SHALL not interact; a write at cycle t SHALL be visible to any read issued at t+1 or later.
REQ-032 Address arithmetic SHALL be modulo RAM_DEPTH; clear pointer SHALL not wrap into a second pass.
REQ-033 DATA_WIDTH not a multiple of BYTE_WIDTH, or READ_LATENCY outside 1..3, SHALL cause an elaboration error.

Reset
REQ-034 rst SHALL set q=0, q_valid=0, clear all read-pipeline valid stages, and select state per REQ-020.
REQ-035 rst mid-operation SHALL discard in-flight reads (no q_valid from next cycle) and restart clear at address 0.
REQ-036 rst asserted during CLEAR SHALL restart clear at 0; with CLEAR_ON_RESET=0, rst SHALL not modify memory.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, BYTE_WIDTH=8, READ_LATENCY=2, CLEAR_VALUE=0)
REQ-037 Clear: rst 1 cycle, then wr_en/rd_en toggling -> busy high exactly 16 cycles, no q_valid; read all 16 addresses -> 0x00000000.
REQ-038 Latency: write 0xDEADBEEF @3, rd_en @3 at cycle t -> q=0xDEADBEEF, q_valid=1 at t+2 only.
REQ-039 Byte enables: 0x11223344 @5, then wr_be=4'b0101 d=0xAABBCCDD @5 -> read 0x11BB33DD.
REQ-040 RDW: mem[7]=0x00000000, same-cycle write 0xCAFEF00D be=4'b1111 and read @7 -> q=0xCAFEF00D (RDW_NEW_DATA=1), 0x00000000 (RDW_NEW_DATA=0).
REQ-041 Streaming: reads @0..15 on consecutive cycles -> 16 consecutive q_valid pulses, data in address order.
REQ-042 Reset mid-read: rd_en issued, rst one cycle later -> no q_valid, q=0, busy high 16 cycles, memory re-cleared.
